matrix_key_scan: RTL and testbench
==================================

# matrix_key_scan

Scanner and debouncer for the 4×4 matrix keypad on the front panel.
- Drives the keypad columns one at a time and samples the rows through a synchroniser.
- Qualifies a single key press over a debounce window and presents its code as a level-valid pair (`key_valid`, `key_value`).
- Sits directly upstream of the key-pattern/mode-select logic, which edge-detects `key_valid` and decodes `key_value` 0–4 as restart/frequency/period/self-test/gate-step.

## Interface
Parameters:
- `SCAN_DIV`, default 50_000: clock cycles per column slot (1 ms at 50 MHz); must be ≥ 4.
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles required for press or release (20 ms at 50 MHz); must be ≥ 2.

Ports:
- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `row`, in, 4: keypad rows, pulled up externally; a pressed key pulls its row low while its column is driven low.
- `col`, out, 4: column drive, active-low, exactly one bit low at any time.
- `key_valid`, out, 1: high while a debounced key is held.
- `key_value`, out, 4: code of the held key, `{row_idx[1:0], col_idx[1:0]}`. Valid while `key_valid` = 1; holds its last value otherwise.

## Operation
- **Row synchroniser:** 2-flop synchroniser `row` → `row_s`; both stages reset to 4'hF. All decisions use `row_s`.
- **One-hot test:** `row_s` has exactly one zero bit (4'b1110 / 1101 / 1011 / 0111). The position of that zero is `row_idx`, 0–3.
- **Counters:**
  - `col_idx` (2 bit) sets `col = ~(4'b0001 << col_idx)`.
  - Slot counter `div_cnt`, 0..SCAN_DIV-1.
  - Debounce counter `deb_cnt`, width ≥ clog2(DEB_CYCLES).

State machine, reset state SCAN:
- **SCAN**
  - `div_cnt` increments each cycle.
  - At `div_cnt == SCAN_DIV-1`: if `row_s` is one-hot, latch `row_code <= row_s`, clear `deb_cnt`, go to DEBOUNCE with `col` held. Otherwise advance `col_idx` (3 wraps to 0).
  - `div_cnt` returns to 0 in both cases.
- **DEBOUNCE** (`col` frozen)
  - If `row_s == row_code`: `deb_cnt++`. On reaching DEB_CYCLES-1, go to PRESSED, set `key_valid <= 1`, and load `key_value <= {row_idx, col_idx}`.
  - If `row_s != row_code`: go to SCAN, advance `col_idx`, clear `div_cnt`.
- **PRESSED** (`key_valid` = 1)
  - If `row_s == 4'hF`: clear `deb_cnt`, go to RELEASE.
  - Any other value, including extra keys pressed, is ignored and the state is kept.
- **RELEASE** (`key_valid` still 1)
  - If `row_s == 4'hF`: `deb_cnt++`. On reaching DEB_CYCLES-1, go to SCAN, set `key_valid <= 0`, advance `col_idx`, clear `div_cnt`.
  - If `row_s != 4'hF`: return to PRESSED (release bounce) and clear `deb_cnt`.

Boundary behaviour:
- **Multiple rows low in one slot:** not one-hot, so the press is rejected and scanning continues.
- **Two keys in different columns:** the first column reached wins. The second key is ignored until full release.
- **Reset mid-operation:** all state is abandoned immediately.

Reset values:
- `col` = 4'b1110, `col_idx` = 0, `key_valid` = 0, `key_value` = 4'd0.
- `div_cnt`, `deb_cnt`, `row_code` cleared; `row_code` clears to 4'hF.
- State = SCAN.

## Timing
- All outputs are registered; `col` changes only on the clock edge after a slot ends.
- Rows are sampled only at the last cycle of a slot, so they settle for SCAN_DIV-1 cycles after each column change. That sample passed through the 2-flop synchroniser, so it reflects the pins 2 cycles earlier.
- Press latency (clean press, detected at slot end T): `key_valid` rises at T + DEB_CYCLES.
- Worst case adds up to 4·SCAN_DIV + 2 cycles before T.
- Release latency: `key_valid` falls DEB_CYCLES+1 cycles after `row_s` first reads 4'hF (the entry cycle to RELEASE plus DEB_CYCLES-1 counting cycles plus the transition edge), i.e. ~DEB_CYCLES+3 cycles after the pins go high.
- `key_valid` pulse width is ≥ DEB_CYCLES+1 cycles, which satisfies the downstream 3-cycle-stable edge detector.
- `key_value` is stable from the cycle `key_valid` rises until the next press is latched.

## Test plan
Bench parameters: SCAN_DIV = 4, DEB_CYCLES = 8, keypad model pulls row r low when column c is low and key (r,c) is pressed.

- **Reset mid-operation:**
  - Stimulus: hold `sys_rst_n` low, release, run 20 cycles with no keys; then press (0,1), pull reset low while in PRESSED, release reset.
  - Response: `col` sequence 1110 → 1101 → 1011 → 0111 → 1110, changing every 4 cycles; `key_valid` = 0. On the mid-operation reset, `key_valid` and `key_value` drop to 0 asynchronously and `col` = 1110.
- **Clean press/release:**
  - Stimulus: press key (0,1) for 40 cycles, then release.
  - Response: `key_valid` rises 8 cycles after the detecting slot end, `key_value` = 4'd1. `key_valid` falls 9 cycles after `row_s` reads 4'hF (~11 cycles after the key releases); `col` then resumes scanning at 1011.
- **Bouncy press:**
  - Stimulus: key (1,0) toggles every 3 cycles for 20 cycles, then holds.
  - Response: no `key_valid` during bounce; a single rise with `key_value` = 4'd4 afterwards.
- **Release bounce:**
  - Stimulus: while key (0,3) is held, open it for 5 cycles, close for 2, then open.
  - Response: `key_valid` stays high through the glitch and falls only after 8 stable open cycles; `key_value` = 4'd3.
- **Two keys, same column:**
  - Stimulus: press (0,2) and (2,2) together.
  - Response: never valid.
- **Two keys, different columns:**
  - Stimulus: press (1,2) and (3,0).
  - Response: the key whose column is reached first is reported. The other key is ignored until all keys are released.

Source files
------------

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner: walks an active-low column drive, synchronises the rows,
// and debounces a single key press/release into a level-valid key code.
module matrix_key_scan #(
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_value
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_nx;
  logic [3:0]       row_m, row_s;
  logic [1:0]       col_idx, col_idx_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [DEB_W-1:0] deb_cnt, deb_nx;
  logic [3:0]       row_code, code_nx;
  logic             valid_nx;
  logic [3:0]       value_nx;
  logic             onehot;
  logic [1:0]       row_idx;

  always_comb begin
    onehot  = 1'b1;
    row_idx = '0;
    unique case (row_s)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: onehot  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    div_nx     = div_cnt;
    deb_nx     = deb_cnt;
    code_nx    = row_code;
    valid_nx   = key_valid;
    value_nx   = key_value;
    unique case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (onehot) begin
            code_nx  = row_s;
            deb_nx   = '0;
            state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_s == row_code) begin
          if (deb_cnt == DEB_LAST) begin
            state_nx = PRESSED;
            valid_nx = 1'b1;
            value_nx = {row_idx, col_idx};
          end else begin
            deb_nx = deb_cnt + 1'b1;
          end
        end else begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
          div_nx     = '0;
        end
      end
      PRESSED: begin
        // extra keys are invisible here; only a fully open row set starts release
        if (row_s == 4'hF) begin
          deb_nx   = '0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (row_s == 4'hF) begin
          if (deb_cnt == DEB_LAST) begin
            state_nx   = SCAN;
            valid_nx   = 1'b0;
            col_idx_nx = col_idx + 2'd1;
            div_nx     = '0;
          end else begin
            deb_nx = deb_cnt + 1'b1;
          end
        end else begin
          state_nx = PRESSED;
          deb_nx   = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      state     <= SCAN;
      col_idx   <= '0;
      col       <= 4'b1110;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      row_code  <= 4'hF;
      key_valid <= 1'b0;
      key_value <= '0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      col       <= ~(4'b0001 << col_idx_nx);
      div_cnt   <= div_nx;
      deb_cnt   <= deb_nx;
      row_code  <= code_nx;
      key_valid <= valid_nx;
      key_value <= value_nx;
    end
  end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: keypad model on the pins, timestamp-based reference
// model compared every cycle, plus directed literal checks per scenario.
module tb_matrix_key_scan;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEB_CYCLES = 8;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_value;

  logic [3:0][3:0] keys;   // keys[r][c] = 1 when key (r,c) is held

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;

  matrix_key_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_value(key_value)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~(|(keys[r] & ~col));
  end

  always @(posedge key_valid) rises++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int zeros(input logic [3:0] v);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) z++;
    return z;
  endfunction

  function automatic int zpos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Reference model: phases with a start-timestamp instead of explicit counters.
  int         m_now, m_mark, m_phase, m_col;
  logic [3:0] m_code, m_value, m_s0, m_s1, rs;
  logic       m_valid;

  task automatic model_step();
    if (!sys_rst_n) begin
      m_now = 0; m_mark = 0; m_phase = 0; m_col = 0;
      m_code = 4'hF; m_value = 4'h0; m_valid = 1'b0;
      m_s0 = 4'hF; m_s1 = 4'hF;
    end else begin
      rs = m_s1;
      case (m_phase)
        0: if (m_now - m_mark == SCAN_DIV - 1) begin
             m_mark = m_now + 1;
             if (zeros(rs) == 1) begin
               m_code = rs; m_phase = 1;
             end else m_col = (m_col + 1) % 4;
           end
        1: if (rs == m_code) begin
             if (m_now - m_mark == DEB_CYCLES - 1) begin
               m_phase = 2; m_valid = 1'b1;
               m_value = 4'(zpos(rs) * 4 + m_col);
             end
           end else begin
             m_phase = 0; m_col = (m_col + 1) % 4; m_mark = m_now + 1;
           end
        2: if (rs == 4'hF) begin
             m_phase = 3; m_mark = m_now + 1;
           end
        default: if (rs == 4'hF) begin
             if (m_now - m_mark == DEB_CYCLES - 1) begin
               m_phase = 0; m_valid = 1'b0; m_col = (m_col + 1) % 4; m_mark = m_now + 1;
             end
           end else m_phase = 2;
      endcase
      m_s1 = m_s0;
      m_s0 = row;
      m_now++;
    end
  endtask

  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    model_step();
  end

  initial forever begin
    logic [3:0] exp_col;
    @(negedge sys_clk);
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    chk("model_col", {28'd0, col}, {28'd0, exp_col});
    chk("model_valid", {31'd0, key_valid}, {31'd0, m_valid});
    chk("model_value", {28'd0, key_value}, {28'd0, m_value});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_kv(input logic lvl, input int lim, output int n);
    n = 0;
    while (key_valid !== lvl && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    if (key_valid !== lvl) chk("wait_timeout", {31'd0, key_valid}, {31'd0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] ecol;
    sys_rst_n = 1'b0;
    keys = '0;
    tick(3);
    chk("reset_col", {28'd0, col}, 32'hE);
    chk("reset_valid", {31'd0, key_valid}, 32'd0);
    chk("reset_value", {28'd0, key_value}, 32'd0);
    sys_rst_n = 1'b1;

    // idle scan: column advances every SCAN_DIV cycles
    for (int k = 1; k < 20; k++) begin
      tick(1);
      ecol = 4'hF;
      ecol[(k / 4) % 4] = 1'b0;
      chk("idle_col", {28'd0, col}, {28'd0, ecol});
      chk("idle_valid", {31'd0, key_valid}, 32'd0);
    end

    // clean press / release of (0,1)
    keys[0][1] = 1'b1;
    wait_kv(1'b1, 100, n);
    chk("clean_value", {28'd0, key_value}, 32'd1);
    if (n < 40) tick(40 - n);
    keys = '0;
    wait_kv(1'b0, 50, n);
    chk("clean_release_lat", n, 32'd11);
    chk("clean_resume_col", {28'd0, col}, 32'hB);
    tick(20);

    // asynchronous reset while a key is held
    keys[0][1] = 1'b1;
    wait_kv(1'b1, 100, n);
    tick(3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, key_valid}, 32'd0);
    chk("midrst_value", {28'd0, key_value}, 32'd0);
    chk("midrst_col", {28'd0, col}, 32'hE);
    keys = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(10);

    // bouncy press of (1,0)
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[1][0] = ~keys[1][0];
      tick(1);
      chk("bounce_no_valid", {31'd0, key_valid}, 32'd0);
    end
    keys[1][0] = 1'b1;
    wait_kv(1'b1, 100, n);
    chk("bounce_value", {28'd0, key_value}, 32'd4);
    tick(10);
    chk("bounce_single_rise", rises, 32'd1);
    keys = '0;
    wait_kv(1'b0, 50, n);
    tick(20);

    // release bounce on (0,3)
    keys[0][3] = 1'b1;
    wait_kv(1'b1, 100, n);
    chk("relb_value", {28'd0, key_value}, 32'd3);
    tick(5);
    keys[0][3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("relb_hold_open", {31'd0, key_valid}, 32'd1);
    end
    keys[0][3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("relb_hold_closed", {31'd0, key_valid}, 32'd1);
    end
    keys[0][3] = 1'b0;
    wait_kv(1'b0, 50, n);
    chk("relb_release_lat", n, 32'd11);
    chk("relb_value_kept", {28'd0, key_value}, 32'd3);
    tick(20);

    // two keys in the same column: never one-hot
    keys[0][2] = 1'b1;
    keys[2][2] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      chk("samecol_no_valid", {31'd0, key_valid}, 32'd0);
    end
    keys = '0;
    tick(10);

    // two keys in different columns from a fresh reset: column 0 is reached first
    sys_rst_n = 1'b0;
    keys[1][2] = 1'b1;
    keys[3][0] = 1'b1;
    tick(1);
    sys_rst_n = 1'b1;
    wait_kv(1'b1, 100, n);
    chk("twocol_value", {28'd0, key_value}, 32'hC);
    tick(20);
    chk("twocol_value_held", {28'd0, key_value}, 32'hC);
    chk("twocol_col_frozen", {28'd0, col}, 32'hE);
    keys = '0;
    wait_kv(1'b0, 50, n);
    chk("twocol_value_after", {28'd0, key_value}, 32'hC);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
